// File: rtl/count_display_scanner_if.sv
// Display-side bundle of count_display_scanner: the raw counter value in and
// the multiplexed seven-segment drive, latched value and frame strobe out.
interface count_display_scanner_if;
    logic [3:0] count;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] value;
    logic       frame_tick;

    modport master (output count, input seg, input an, input value, input frame_tick);
    modport slave  (input count, output seg, output an, output value, output frame_tick);
endinterface

// File: rtl/count_display_scanner.sv
// Two-digit multiplexed seven-segment scanner for a glitchy ripple-counter value.
// Optional LEADING_ZERO_BLANK_EN: leave the tens digit dark when it is zero.
module count_display_scanner #(
    parameter int unsigned REFRESH_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES     = 500,
    parameter int unsigned SEG_ACTIVE_LOW   = 1,
    parameter int unsigned DIGIT_ACTIVE_LOW = 1
) (
    input  logic                   clock,
    input  logic                   clear,
    count_display_scanner_if.slave bus
);

    localparam int unsigned MAX_DIV = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    localparam logic [CNT_W-1:0] DIG_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [6:0]       SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0]       AN_OFF     = (DIGIT_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {
        DIG0   = 2'd0,
        BLANK0 = 2'd1,
        DIG1   = 2'd2,
        BLANK1 = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [3:0]       s1_q, s1_d;
    logic [3:0]       s2_q, s2_d;
    logic [3:0]       value_q, value_d;
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             frame_tick_q, frame_tick_d;

    // s3 only feeds the stability compare, so its next value is used directly
    logic [3:0] s3_d;
    logic       tens_dec;
    logic [3:0] ones_dec;
    logic       lit;
    logic [1:0] an_on;
    logic [6:0] pat;

    // Active-high {g,f,e,d,c,b,a} pattern for a decimal digit
    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] p;
        case (digit)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q      <= BLANK1;
            presc_q      <= '0;
            s1_q         <= 4'd0;
            s2_q         <= 4'd0;
            value_q      <= 4'd0;
            ones_q       <= 4'd0;
            tens_q       <= 4'd0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            value_q      <= value_d;
            ones_q       <= ones_d;
            tens_q       <= tens_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q + CNT_W'(1);
        s1_d         = bus.count;
        s2_d         = s1_q;
        s3_d         = s2_q;
        value_d      = value_q;
        ones_d       = ones_q;
        tens_d       = tens_q;
        lit          = 1'b0;
        an_on        = 2'b00;
        pat          = 7'h00;
        seg_d        = SEG_OFF;
        an_d         = AN_OFF;
        frame_tick_d = 1'b0;

        // Latch only a value that sits in both s2 and s3 after this edge
        if (s2_d == s3_d) begin
            value_d = s2_d;
        end

        tens_dec = (value_q >= 4'd10);
        ones_dec = tens_dec ? (value_q - 4'd10) : value_q;

        case (state_q)
            DIG0: begin
                if (presc_q == DIG_LAST) begin
                    state_d = BLANK0;
                    presc_d = '0;
                end
            end
            BLANK0: begin
                if (presc_q == BLANK_LAST) begin
                    state_d = DIG1;
                    presc_d = '0;
                end
            end
            DIG1: begin
                if (presc_q == DIG_LAST) begin
                    state_d = BLANK1;
                    presc_d = '0;
                end
            end
            BLANK1: begin
                if (presc_q == BLANK_LAST) begin
                    state_d = DIG0;
                    presc_d = '0;
                    // Digits change only here, so a lit slot never flickers
                    ones_d  = ones_dec;
                    tens_d  = tens_dec ? 4'd1 : 4'd0;
                end
            end
            default: begin
                state_d = BLANK1;
                presc_d = '0;
            end
        endcase

        // Registered outputs are built from the state being entered
        case (state_d)
            DIG0: begin
                an_on = 2'b01;
                pat   = seg_pattern(ones_d);
                lit   = 1'b1;
            end
            DIG1: begin
                pat = seg_pattern(tens_d);
`ifdef LEADING_ZERO_BLANK_EN
                if (tens_d != 4'd0) begin
                    an_on = 2'b10;
                    lit   = 1'b1;
                end
`else
                an_on = 2'b10;
                lit   = 1'b1;
`endif
            end
            default: begin
                an_on = 2'b00;
                lit   = 1'b0;
            end
        endcase

        if (lit) begin
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
        end
        an_d         = AN_OFF ^ an_on;
        frame_tick_d = (state_d == BLANK1) && (presc_d == BLANK_LAST);
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.value      = value_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_count_display_scanner.sv
// Directed bench for count_display_scanner with an 8-cycle slot and 2-cycle blank.
module tb_count_display_scanner;

    logic clock;
    logic clear;
    int   total;
    int   bad;

    count_display_scanner_if bus();

    count_display_scanner #(
        .REFRESH_DIV     (8),
        .BLANK_CYCLES    (2),
        .SEG_ACTIVE_LOW  (1),
        .DIGIT_ACTIVE_LOW(1)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] cnt;
        logic [6:0] seg0;
        logic [6:0] seg1;
        logic [1:0] an1;
    } vec_t;

    vec_t vecs[7];

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Bounded wait for the end-of-frame strobe
    task automatic wait_frame();
        int n;
        n = 0;
        while (bus.frame_tick !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (bus.frame_tick !== 1'b1) begin
            bad++;
            $display("FAIL frame_wait: frame_tick=%0b required 1 within 100 cycles", bus.frame_tick);
        end
    endtask

    initial begin
        logic [1:0] exp_an;
        logic [3:0] prev;
        total = 0;
        bad   = 0;

        vecs[0] = '{4'd7,  7'b1111000, 7'b1000000, 2'b01};
        vecs[1] = '{4'd13, 7'b0110000, 7'b1111001, 2'b01};
        vecs[2] = '{4'd0,  7'h40,      7'h40,      2'b01};
        vecs[3] = '{4'd15, 7'h12,      7'h79,      2'b01};
        vecs[4] = '{4'd10, 7'h40,      7'h79,      2'b01};
        vecs[5] = '{4'd9,  7'h10,      7'h40,      2'b01};
        vecs[6] = '{4'd5,  7'h12,      7'h40,      2'b01};
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].cnt < 4'd10) begin
                vecs[i].seg1 = 7'h7F;
                vecs[i].an1  = 2'b11;
            end
        end
`endif

        // Reset and first scan after release
        clear     = 1'b0;
        bus.count = 4'd0;
        step(3);
        check("reset_seg", 32'(bus.seg), 32'h7F);
        check("reset_an", 32'(bus.an), 32'h3);
        check("reset_value", 32'(bus.value), 32'h0);
        check("reset_tick", 32'(bus.frame_tick), 32'h0);
        clear = 1'b1;
        step(1);
        check("release_an_1", 32'(bus.an), 32'h3);
        check("release_tick_1", 32'(bus.frame_tick), 32'h1);
        step(1);
        check("release_an_2", 32'(bus.an), 32'h2);
        check("release_seg_2", 32'(bus.seg), 32'h40);

        // One full frame of slot timing, count = 0
        for (int i = 0; i < 20; i++) begin
            if (i < 8)       exp_an = 2'b10;
            else if (i < 10) exp_an = 2'b11;
`ifdef LEADING_ZERO_BLANK_EN
            else if (i < 18) exp_an = 2'b11;
`else
            else if (i < 18) exp_an = 2'b01;
`endif
            else             exp_an = 2'b11;
            check($sformatf("timing_an_%0d", i), 32'(bus.an), 32'(exp_an));
            check($sformatf("timing_tick_%0d", i), 32'(bus.frame_tick), (i == 19) ? 32'h1 : 32'h0);
            if (i == 10) begin
`ifdef LEADING_ZERO_BLANK_EN
                check("timing_seg_dig1", 32'(bus.seg), 32'h7F);
`else
                check("timing_seg_dig1", 32'(bus.seg), 32'h40);
`endif
            end
            if (i < 19) step(1);
        end

        // Table: filter latency then displayed digits in the next frame
        prev = 4'd0;
        for (int i = 0; i < 7; i++) begin
            bus.count = vecs[i].cnt;
            step(2);
            check($sformatf("vec%0d_value_hold", i), 32'(bus.value), 32'(prev));
            step(1);
            check($sformatf("vec%0d_value", i), 32'(bus.value), 32'(vecs[i].cnt));
            wait_frame();
            step(1);
            check($sformatf("vec%0d_an0", i), 32'(bus.an), 32'h2);
            check($sformatf("vec%0d_seg0", i), 32'(bus.seg), 32'(vecs[i].seg0));
            step(10);
            check($sformatf("vec%0d_an1", i), 32'(bus.an), 32'(vecs[i].an1));
            check($sformatf("vec%0d_seg1", i), 32'(bus.seg), 32'(vecs[i].seg1));
            prev = vecs[i].cnt;
        end

        // Single-cycle glitch is rejected, a two-cycle value is latched
        bus.count = 4'd7;
        step(4);
        check("glitch_pre", 32'(bus.value), 32'h7);
        bus.count = 4'd6;
        step(1);
        bus.count = 4'd7;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check($sformatf("glitch_hold_%0d", i), 32'(bus.value), 32'h7);
        end
        bus.count = 4'd6;
        step(2);
        bus.count = 4'd7;
        step(1);
        check("two_cycle_latch", 32'(bus.value), 32'h6);

        // Reset asserted in the middle of DIG1
        bus.count = 4'd13;
        step(4);
        check("mid_value", 32'(bus.value), 32'hD);
        wait_frame();
        step(14);
        check("mid_an_dig1", 32'(bus.an), 32'h1);
        clear = 1'b0;
        step(1);
        check("mid_rst_seg", 32'(bus.seg), 32'h7F);
        check("mid_rst_an", 32'(bus.an), 32'h3);
        check("mid_rst_value", 32'(bus.value), 32'h0);
        check("mid_rst_tick", 32'(bus.frame_tick), 32'h0);
        clear = 1'b1;
        step(1);
        check("mid_rel_an_1", 32'(bus.an), 32'h3);
        step(1);
        check("mid_rel_an_2", 32'(bus.an), 32'h2);
        check("mid_rel_seg_2", 32'(bus.seg), 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
